// File: rtl/pc_next_unit.sv
// pc_next_unit: PC register and next-PC selection for the fetch stage.
// Selects among sequential, JALR, BRANCH, JAL, MTVEC and MEPC targets, buffers a
// redirect that arrives during a stall, and pulses FLUSH/ERR/MISALIGN for one cycle.
// Optional feature: define PC_MISALIGN_CHK_EN to trap misaligned redirect targets
// to MTVEC instead of silently masking their low bits.
module pc_next_unit #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int              IALIGN    = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            STALL,
  input  logic [2:0]      PC_SOURCE,
  input  logic [XLEN-1:0] JALR,
  input  logic [XLEN-1:0] BRANCH,
  input  logic [XLEN-1:0] JAL,
  input  logic [XLEN-1:0] MTVEC,
  input  logic [XLEN-1:0] MEPC,
  output logic [XLEN-1:0] PC_OUT,
  output logic [XLEN-1:0] PC_PLUS,
  output logic            FLUSH,
  output logic            PEND,
  output logic            ERR,
  output logic            MISALIGN
);

  localparam int              INC       = IALIGN / 8;
  localparam logic [XLEN-1:0] INC_V     = XLEN'(INC);
  localparam logic [XLEN-1:0] LOW_MASK  = XLEN'(INC - 1);
  localparam logic [XLEN-1:0] BIT0_MASK = XLEN'(1);
  localparam logic [XLEN-1:0] TVEC_MASK = XLEN'(3);

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] buf_tgt_q, buf_tgt_d;
  logic [1:0]      buf_pri_q, buf_pri_d;
  logic            pend_q, pend_d;
  logic            flush_q, flush_d;
  logic            err_q, err_d;
  logic            mis_q, mis_d;

  logic [XLEN-1:0] jalr_c, branch_c, jal_c, mtvec_c, mepc_c;
  logic [XLEN-1:0] sel_tgt;
  logic [1:0]      sel_pri;
  logic            is_redir;
  logic            is_rsvd;
  logic            commit_en;
  logic            commit_nonseq;
  logic [XLEN-1:0] commit_tgt;

  assign PC_PLUS = pc_q + INC_V;

  // Condition raw targets: JALR drops bit0, MTVEC is always word aligned.
  always_comb begin
    jalr_c   = JALR & ~BIT0_MASK;
    branch_c = BRANCH;
    jal_c    = JAL;
    mtvec_c  = MTVEC & ~TVEC_MASK;
    mepc_c   = MEPC;
`ifndef PC_MISALIGN_CHK_EN
    // Without the trap check, low bits below the instruction alignment are masked.
    jalr_c   = jalr_c & ~LOW_MASK;
    branch_c = branch_c & ~LOW_MASK;
    jal_c    = jal_c & ~LOW_MASK;
    mtvec_c  = mtvec_c & ~LOW_MASK;
    mepc_c   = mepc_c & ~LOW_MASK;
`endif
  end

  // Decode PC_SOURCE into a target, its priority and its class.
  always_comb begin
    sel_tgt  = PC_PLUS;
    sel_pri  = 2'd0;
    is_redir = 1'b0;
    is_rsvd  = 1'b0;
    case (PC_SOURCE)
      3'b001:  begin sel_tgt = jalr_c;   sel_pri = 2'd1; is_redir = 1'b1; end
      3'b010:  begin sel_tgt = branch_c; sel_pri = 2'd1; is_redir = 1'b1; end
      3'b011:  begin sel_tgt = jal_c;    sel_pri = 2'd1; is_redir = 1'b1; end
      3'b100:  begin sel_tgt = mtvec_c;  sel_pri = 2'd3; is_redir = 1'b1; end
      3'b101:  begin sel_tgt = mepc_c;   sel_pri = 2'd2; is_redir = 1'b1; end
      3'b110,
      3'b111:  is_rsvd = 1'b1;
      default: sel_tgt = PC_PLUS;
    endcase
  end

  // State machine: pick what (if anything) commits to the PC and manage the redirect buffer.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    buf_tgt_d     = buf_tgt_q;
    buf_pri_d     = buf_pri_q;
    pend_d        = pend_q;
    flush_d       = 1'b0;
    err_d         = 1'b0;
    mis_d         = 1'b0;
    commit_en     = 1'b0;
    commit_nonseq = 1'b0;
    commit_tgt    = pc_q;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        err_d = is_rsvd;
        if (!STALL) begin
          commit_en     = 1'b1;
          commit_tgt    = sel_tgt;
          commit_nonseq = is_redir;
        end else if (is_redir) begin
          buf_tgt_d = sel_tgt;
          buf_pri_d = sel_pri;
          pend_d    = 1'b1;
          state_d   = ST_HOLD;
        end
      end
      ST_HOLD: begin
        err_d = is_rsvd;
        if (STALL) begin
          // Newer redirect wins unless the buffered one outranks it.
          if (is_redir && (sel_pri >= buf_pri_q)) begin
            buf_tgt_d = sel_tgt;
            buf_pri_d = sel_pri;
          end
        end else begin
          commit_en     = 1'b1;
          commit_nonseq = 1'b1;
          commit_tgt    = (PC_SOURCE == 3'b100) ? mtvec_c : buf_tgt_q;
          pend_d        = 1'b0;
          state_d       = ST_RUN;
        end
      end
      default: state_d = ST_BOOT;
    endcase

    if (commit_en) begin
      pc_d    = commit_tgt;
      flush_d = commit_nonseq;
`ifdef PC_MISALIGN_CHK_EN
      // A misaligned redirect is not taken; it traps to the vector instead.
      if (commit_nonseq && ((commit_tgt & LOW_MASK) != '0)) begin
        pc_d    = mtvec_c;
        mis_d   = 1'b1;
        flush_d = 1'b1;
      end
`endif
    end
  end

  // State registers; reset discards any buffered redirect.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_BOOT;
      pc_q      <= RESET_VEC;
      buf_tgt_q <= '0;
      buf_pri_q <= 2'd0;
      pend_q    <= 1'b0;
      flush_q   <= 1'b0;
      err_q     <= 1'b0;
      mis_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      buf_tgt_q <= buf_tgt_d;
      buf_pri_q <= buf_pri_d;
      pend_q    <= pend_d;
      flush_q   <= flush_d;
      err_q     <= err_d;
      mis_q     <= mis_d;
    end
  end

  assign PC_OUT = pc_q;
  assign FLUSH  = flush_q;
  assign PEND   = pend_q;
  assign ERR    = err_q;
`ifdef PC_MISALIGN_CHK_EN
  assign MISALIGN = mis_q;
`else
  assign MISALIGN = 1'b0;
  logic unused_mis;
  assign unused_mis = mis_q;
`endif

endmodule
